pixie_dma_responder: RTL and testbench

PIXIE_DMA_RESPONDER -- requirements
Module: pixie_dma_responder

---
 rtl/pixie_dma_responder.sv | 100 ++++++++++
 tb/tb_pixie_dma_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dma_responder.sv
// Pixie DMA-out responder: fetches 8-byte bursts from RAM at the display pointer
// and presents them to the video generator. Define PIXIE_DMA_PAGE_WRAP_EN to keep ptr inside a 256-byte page.
module pixie_dma_responder (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        dma_out_req,
    input  logic        frame_int,
    input  logic [15:0] base_addr,
    output logic        ram_rd,
    output logic [15:0] ram_a,
    input  logic [7:0]  ram_q,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic [15:0] ptr
);

    typedef enum logic [1:0] {IDLE, READ, LATCH, PRESENT} state_t;

    state_t      state, state_n;
    logic [2:0]  cnt;
    logic        pending;
    logic        accept, xfer, last;
    logic [15:0] ptr_inc, ptr_n;

`ifdef PIXIE_DMA_PAGE_WRAP_EN
    assign ptr_inc = {ptr[15:8], ptr[7:0] + 8'd1};
`else
    assign ptr_inc = ptr + 16'd1;
`endif

    assign last   = (cnt == 3'd7);
    assign ram_rd = ce && !reset && (state == READ);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        xfer    = 1'b0;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                // reload and acceptance may coincide; the first READ then sees base_addr
                if (frame_int) ptr_n = base_addr;
                if (dma_out_req) begin
                    accept  = 1'b1;
                    state_n = READ;
                end
            end
            READ:  state_n = LATCH;
            LATCH: state_n = PRESENT;
            PRESENT: begin
                if (pix_ready) begin
                    xfer    = 1'b1;
                    ptr_n   = (last && (pending || frame_int)) ? base_addr : ptr_inc;
                    state_n = last ? IDLE : READ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= state_n;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt       <= 3'd0;
            pending   <= 1'b0;
            ram_a     <= 16'h0000;
            pix_data  <= 8'h00;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= base_addr;
        end else if (ce) begin
            ptr  <= ptr_n;
            busy <= (state_n != IDLE);
            // ram_a is loaded on entry to READ so it equals ptr throughout READ
            if (state_n == READ) ram_a <= ptr_n;
            if (accept)    cnt <= 3'd0;
            else if (xfer) cnt <= cnt + 3'd1;
            if (state == LATCH) begin
                pix_data  <= ram_q;
                pix_valid <= 1'b1;
            end else if (xfer) begin
                pix_valid <= 1'b0;
            end
            if (xfer && last)
                pending <= 1'b0;
            else if (state != IDLE && frame_int)
                pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixie_dma_responder.sv
// Directed bench for pixie_dma_responder: RAM model, bus monitor and hand-computed vectors.
module tb_pixie_dma_responder;

    logic        clk_sys = 1'b0;
    logic        reset, ce, dma_out_req, frame_int, pix_ready;
    logic [15:0] base_addr;
    logic        ram_rd, pix_valid, busy;
    logic [15:0] ram_a, ptr;
    logic [7:0]  ram_q, pix_data;

    int n_chk = 0;
    int n_err = 0;
    int viol  = 0;
    int cyc   = 0;
    logic [15:0] rd_q[$];
    int          rd_cyc[$];
    logic [7:0]  xfer_q[$];

    always #5 clk_sys = ~clk_sys;

    pixie_dma_responder dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .dma_out_req(dma_out_req),
        .frame_int(frame_int), .base_addr(base_addr), .ram_rd(ram_rd), .ram_a(ram_a),
        .ram_q(ram_q), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .ptr(ptr)
    );

    function automatic logic [7:0] ramf(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    function automatic logic [15:0] nxt(input logic [15:0] a);
`ifdef PIXIE_DMA_PAGE_WRAP_EN
        return {a[15:8], a[7:0] + 8'd1};
`else
        return a + 16'd1;
`endif
    endfunction

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (ram_rd) ram_q <= ramf(ram_a);
    end

    always @(negedge clk_sys) begin
        if (ram_rd) begin
            rd_q.push_back(ram_a);
            rd_cyc.push_back(cyc);
            if (!ce || !busy) viol++;
        end
        if (pix_valid && pix_ready && ce && !reset) xfer_q.push_back(pix_data);
        if (pix_valid && !busy) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        rd_cyc.delete();
        xfer_q.delete();
    endtask

    task automatic start_burst();
        dma_out_req = 1'b1;
        step(1);
        dma_out_req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && busy; k++) step(1);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid(input int bound);
        for (int k = 0; k < bound && !pix_valid; k++) step(1);
        chk("valid_timeout", {31'd0, pix_valid}, 32'd1);
    endtask

    task automatic check_burst(input string tag, input logic [15:0] a0);
        logic [15:0] a;
        a = a0;
        chk({tag, "_nrd"}, rd_q.size(), 32'd8);
        chk({tag, "_nxfer"}, xfer_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_q.size() && i < xfer_q.size()) begin
                chk({tag, "_addr"}, {16'd0, rd_q[i]}, {16'd0, a});
                chk({tag, "_data"}, {24'd0, xfer_q[i]}, {24'd0, ramf(a)});
            end
            a = nxt(a);
        end
    endtask

    initial begin
        logic [7:0]  d0;
        int          n0, unstable;
        reset = 1'b1; ce = 1'b1; dma_out_req = 1'b0; frame_int = 1'b0;
        pix_ready = 1'b1; base_addr = 16'h0900;
        step(2);
        reset = 1'b0;
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ptr", {16'd0, ptr}, 32'h0900);
        chk("rst_ram_a", {16'd0, ram_a}, 32'h0000);
        chk("rst_pix_data", {24'd0, pix_data}, 32'h00);
        chk("rst_ram_rd", {31'd0, ram_rd}, 32'd0);

        // basic burst with latency check
        clear_mon();
        start_burst();
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_rd", {31'd0, ram_rd}, 32'd1);
        chk("lat_ram_a", {16'd0, ram_a}, 32'h0900);
        step(1);
        chk("lat_valid_early", {31'd0, pix_valid}, 32'd0);
        step(1);
        chk("lat_valid", {31'd0, pix_valid}, 32'd1);
        wait_idle(100);
        check_burst("burst1", 16'h0900);
        chk("burst1_ptr", {16'd0, ptr}, 32'h0908);

        // stall on byte 3
        clear_mon();
        pix_ready = 1'b0;
        start_burst();
        for (int b = 0; b < 8; b++) begin
            wait_valid(20);
            if (b == 2) begin
                d0 = pix_data;
                n0 = rd_q.size();
                unstable = 0;
                repeat (10) begin
                    step(1);
                    if (!pix_valid || pix_data !== d0) unstable++;
                end
                chk("stall_stable", unstable, 32'd0);
                chk("stall_no_rd", rd_q.size(), n0);
            end
            pix_ready = 1'b1;
            step(1);
            pix_ready = 1'b0;
        end
        pix_ready = 1'b1;
        wait_idle(20);
        check_burst("stall", 16'h0908);

        // frame_int mid-burst
        base_addr = 16'h0940; frame_int = 1'b1;
        step(1);
        frame_int = 1'b0; base_addr = 16'h0900;
        chk("reload_ptr", {16'd0, ptr}, 32'h0940);
        clear_mon();
        start_burst();
        for (int k = 0; k < 50 && xfer_q.size() < 3; k++) step(1);
        frame_int = 1'b1;
        step(1);
        frame_int = 1'b0;
        wait_idle(100);
        check_burst("frame", 16'h0940);
        chk("frame_ptr", {16'd0, ptr}, 32'h0900);
        clear_mon();
        start_burst();
        wait_idle(100);
        check_burst("after_frame", 16'h0900);

        // page boundary
        base_addr = 16'h09FC; frame_int = 1'b1;
        step(1);
        frame_int = 1'b0; base_addr = 16'h0900;
        clear_mon();
        start_burst();
        wait_idle(100);
        check_burst("wrap", 16'h09FC);
`ifdef PIXIE_DMA_PAGE_WRAP_EN
        chk("wrap_ptr", {16'd0, ptr}, 32'h0904);
`else
        chk("wrap_ptr", {16'd0, ptr}, 32'h0A04);
`endif

        // reload and accept in the same cycle
        base_addr = 16'h0A10; frame_int = 1'b1; dma_out_req = 1'b1;
        step(1);
        frame_int = 1'b0; dma_out_req = 1'b0;
        chk("combo_rd", {31'd0, ram_rd}, 32'd1);
        chk("combo_ram_a", {16'd0, ram_a}, 32'h0A10);
        wait_idle(100);
        base_addr = 16'h0900;

        // reset in LATCH of byte 2
        clear_mon();
        start_burst();
        for (int k = 0; k < 50 && xfer_q.size() < 1; k++) step(1);
        for (int k = 0; k < 50 && !ram_rd; k++) step(1);
        chk("mid_rd_seen", {31'd0, ram_rd}, 32'd1);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ptr", {16'd0, ptr}, 32'h0900);
        chk("mid_rst_rd", {31'd0, ram_rd}, 32'd0);
        n0 = rd_q.size();
        step(10);
        chk("mid_rst_no_rd", rd_q.size(), n0);
        chk("mid_rst_xfers", xfer_q.size(), 32'd1);

        // ce active one cycle in four
        clear_mon();
        for (int k = 0; k < 400 && (k < 8 || busy); k++) begin
            ce = (k % 4 == 0);
            if (k == 0) dma_out_req = 1'b1;
            else if (busy) dma_out_req = 1'b0;
            step(1);
        end
        ce = 1'b1;
        dma_out_req = 1'b0;
        chk("ce_idle", {31'd0, busy}, 32'd0);
        check_burst("ce4", 16'h0900);
        if (rd_cyc.size() == 8) chk("ce4_span", rd_cyc[7] - rd_cyc[0], 32'd84);
        else chk("ce4_span_count", rd_cyc.size(), 32'd8);

        chk("protocol_viol", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
